// File: rtl/dispatch_issue_if.sv
// Dispatch/issue port bundle: decoded instruction input, illegal pulse, and
// the three per-unit issue queue heads (int, mem, br).
interface dispatch_issue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [12:0]      in_ctrl;
  logic             illegal;

  logic             int_valid, mem_valid, br_valid;
  logic             int_ready, mem_ready, br_ready;
  logic [31:0]      int_inst, mem_inst, br_inst;
  logic [12:0]      int_ctrl, mem_ctrl, br_ctrl;
  logic [TAG_W-1:0] int_tag, mem_tag, br_tag;
  logic [CW-1:0]    int_count, mem_count, br_count;

  modport slave (
    input  flush, in_valid, in_inst, in_ctrl, int_ready, mem_ready, br_ready,
    output in_ready, illegal,
    output int_valid, int_inst, int_ctrl, int_tag, int_count,
    output mem_valid, mem_inst, mem_ctrl, mem_tag, mem_count,
    output br_valid, br_inst, br_ctrl, br_tag, br_count
  );

  modport master (
    output flush, in_valid, in_inst, in_ctrl, int_ready, mem_ready, br_ready,
    input  in_ready, illegal,
    input  int_valid, int_inst, int_ctrl, int_tag, int_count,
    input  mem_valid, mem_inst, mem_ctrl, mem_tag, mem_count,
    input  br_valid, br_inst, br_ctrl, br_tag, br_count
  );
endinterface

// File: rtl/dispatch_issue.sv
// Routes decoded instructions into int/mem/br issue FIFOs, stamping each with
// a wrapping sequence tag; all-inactive control words are dropped and flagged.
module dispatch_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  dispatch_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + 13 + TAG_W;
  localparam int NQ = 3;

  typedef enum logic [1:0] {CL_INT = 2'd0, CL_MEM = 2'd1, CL_BR = 2'd2, CL_ILL = 2'd3} cls_e;

  cls_e             cls;
  logic             tgt_full, in_ready_c, accept;
  logic [NQ-1:0]    push, pop, q_ready;
  logic [PW-1:0]    wr_ptr_q [NQ], wr_ptr_d [NQ];
  logic [PW-1:0]    rd_ptr_q [NQ], rd_ptr_d [NQ];
  logic [CW-1:0]    count_q  [NQ], count_d  [NQ];
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;
  logic [EW-1:0]    fifo_mem [NQ][DEPTH];

  assign q_ready = {bus.br_ready, bus.mem_ready, bus.int_ready};

  // Priority matters: a load with RegWrite must go to mem, jal with RegWrite to br.
  always_comb begin
    cls = CL_ILL;
    if (bus.in_ctrl[4] | bus.in_ctrl[3])                        cls = CL_MEM;
    else if (bus.in_ctrl[5] | bus.in_ctrl[7] | bus.in_ctrl[6])  cls = CL_BR;
    else if (bus.in_ctrl[1])                                    cls = CL_INT;
  end

  // Full is judged on registered count; a same-cycle pop does not free a slot.
  always_comb begin
    tgt_full = 1'b0;
    for (int u = 0; u < NQ; u++)
      if (cls == cls_e'(u)) tgt_full = (count_q[u] == CW'(DEPTH));
    in_ready_c = ~rst & ~bus.flush & ((cls == CL_ILL) | ~tgt_full);
    accept     = bus.in_valid & in_ready_c;
  end

  always_comb begin
    tag_d     = tag_q;
    illegal_d = accept & (cls == CL_ILL);
    if (accept && cls != CL_ILL) tag_d = tag_q + TAG_W'(1);
    for (int u = 0; u < NQ; u++) begin
      push[u]     = accept & (cls == cls_e'(u));
      pop[u]      = q_ready[u] & (count_q[u] != '0) & ~bus.flush;
      wr_ptr_d[u] = wr_ptr_q[u];
      rd_ptr_d[u] = rd_ptr_q[u];
      count_d[u]  = count_q[u];
      if (bus.flush) begin
        wr_ptr_d[u] = '0;
        rd_ptr_d[u] = '0;
        count_d[u]  = '0;
      end else begin
        if (push[u]) wr_ptr_d[u] = wr_ptr_q[u] + PW'(1);
        if (pop[u])  rd_ptr_d[u] = rd_ptr_q[u] + PW'(1);
        case ({push[u], pop[u]})
          2'b10:   count_d[u] = count_q[u] + CW'(1);
          2'b01:   count_d[u] = count_q[u] - CW'(1);
          default: count_d[u] = count_q[u];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      illegal_q <= 1'b0;
      for (int u = 0; u < NQ; u++) begin
        wr_ptr_q[u] <= '0;
        rd_ptr_q[u] <= '0;
        count_q[u]  <= '0;
      end
    end else begin
      tag_q     <= tag_d;
      illegal_q <= illegal_d;
      for (int u = 0; u < NQ; u++) begin
        wr_ptr_q[u] <= wr_ptr_d[u];
        rd_ptr_q[u] <= rd_ptr_d[u];
        count_q[u]  <= count_d[u];
      end
    end
  end

  // Storage holds data only; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NQ; u++)
      if (push[u]) fifo_mem[u][wr_ptr_q[u]] <= {bus.in_inst, bus.in_ctrl, tag_q};
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.illegal   = illegal_q;

  assign bus.int_valid = (count_q[0] != '0);
  assign bus.int_count = count_q[0];
  assign {bus.int_inst, bus.int_ctrl, bus.int_tag} = fifo_mem[0][rd_ptr_q[0]];

  assign bus.mem_valid = (count_q[1] != '0);
  assign bus.mem_count = count_q[1];
  assign {bus.mem_inst, bus.mem_ctrl, bus.mem_tag} = fifo_mem[1][rd_ptr_q[1]];

  assign bus.br_valid  = (count_q[2] != '0);
  assign bus.br_count  = count_q[2];
  assign {bus.br_inst, bus.br_ctrl, bus.br_tag} = fifo_mem[2][rd_ptr_q[2]];
endmodule

// File: tb/tb_dispatch_issue.sv
// Directed bench for dispatch_issue with a per-FIFO scoreboard queue model.
module tb_dispatch_issue;
  localparam logic [12:0] C_RT  = 13'h002;
  localparam logic [12:0] C_LW  = 13'h012;
  localparam logic [12:0] C_SW  = 13'h00C;
  localparam logic [12:0] C_BEQ = 13'h020;
  localparam logic [12:0] C_JAL = 13'h082;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_issue_if #(.DEPTH(4), .TAG_W(4)) bus ();
  dispatch_issue #(.DEPTH(4), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [2:0]  q_rdy = 3'b000;
  assign bus.int_ready = q_rdy[0];
  assign bus.mem_ready = q_rdy[1];
  assign bus.br_ready  = q_rdy[2];

  logic        dv [3];
  logic [48:0] dh [3];
  logic [2:0]  dc [3];
  assign dv[0] = bus.int_valid;  assign dh[0] = {bus.int_inst, bus.int_ctrl, bus.int_tag};
  assign dv[1] = bus.mem_valid;  assign dh[1] = {bus.mem_inst, bus.mem_ctrl, bus.mem_tag};
  assign dv[2] = bus.br_valid;   assign dh[2] = {bus.br_inst, bus.br_ctrl, bus.br_tag};
  assign dc[0] = bus.int_count;  assign dc[1] = bus.mem_count;  assign dc[2] = bus.br_count;

  int          errors = 0;
  int          checks = 0;
  logic [48:0] mq [3][$];
  logic [3:0]  mtag = 4'd0;
  logic        mill = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int cls_of(input logic [12:0] c);
    if (c[4] || c[3]) return 1;
    if (c[5] || c[7] || c[6]) return 2;
    if (c[1]) return 0;
    return 3;
  endfunction

  task automatic put(input logic v, input logic [31:0] inst, input logic [12:0] ctrl);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_ctrl  = ctrl;
  endtask

  // One clock: compare DUT against the scoreboard mid-cycle, then advance the model.
  task automatic cycle();
    int   c;
    logic exp_rdy;
    @(negedge clk);
    c = cls_of(bus.in_ctrl);
    exp_rdy = !rst && !bus.flush && (c == 3 || mq[c].size() < 4);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("count%0d", u), 64'(dc[u]), 64'(mq[u].size()));
      chk($sformatf("valid%0d", u), 64'(dv[u]), 64'(mq[u].size() != 0));
      if (mq[u].size() != 0) chk($sformatf("head%0d", u), 64'(dh[u]), 64'(mq[u][0]));
    end
    if (bus.in_valid || rst) chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("illegal", 64'(bus.illegal), 64'(mill));
    if (rst) begin
      for (int u = 0; u < 3; u++) mq[u].delete();
      mtag = 4'd0;
      mill = 1'b0;
    end else if (bus.flush) begin
      for (int u = 0; u < 3; u++) mq[u].delete();
      mill = 1'b0;
    end else begin
      for (int u = 0; u < 3; u++)
        if (q_rdy[u] && mq[u].size() != 0) void'(mq[u].pop_front());
      mill = bus.in_valid && exp_rdy && c == 3;
      if (bus.in_valid && exp_rdy && c != 3) begin
        mq[c].push_back({bus.in_inst, bus.in_ctrl, mtag});
        mtag = mtag + 4'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;
    put(1'b0, 32'h0, 13'h0);
    repeat (2) @(posedge clk);
    #1;
    put(1'b1, 32'h002081B3, C_RT);
    cycle();
    rst = 1'b0;

    // Routing
    put(1'b1, 32'h002081B3, C_RT);   cycle();
    put(1'b1, 32'h0000A103, C_LW);   cycle();
    put(1'b1, 32'h00208463, C_BEQ);  cycle();
    put(1'b1, 32'h008000EF, C_JAL);  cycle();
    put(1'b0, 32'h0, 13'h0);
    chk("route_int_cnt", 64'(bus.int_count), 64'd1);
    chk("route_int_tag", 64'(bus.int_tag), 64'd0);
    chk("route_mem_cnt", 64'(bus.mem_count), 64'd1);
    chk("route_mem_tag", 64'(bus.mem_tag), 64'd1);
    chk("route_br_cnt", 64'(bus.br_count), 64'd2);
    chk("route_br_tag", 64'(bus.br_tag), 64'd2);
    q_rdy = 3'b100; cycle();
    chk("route_br_tag2", 64'(bus.br_tag), 64'd3);
    q_rdy = 3'b111; cycle(); cycle();

    // Full / backpressure
    q_rdy = 3'b000;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'h00000033 | (32'(i) << 7), C_RT);
      cycle();
    end
    chk("full_cnt", 64'(bus.int_count), 64'd4);
    put(1'b1, 32'h00000233, C_RT);  #1;
    chk("full_rdy_rt", 64'(bus.in_ready), 64'd0);
    put(1'b1, 32'h0000A103, C_LW);  #1;
    chk("full_rdy_lw", 64'(bus.in_ready), 64'd1);
    put(1'b1, 32'h00000233, C_RT);
    q_rdy = 3'b001; cycle();
    chk("full_pop_cnt", 64'(bus.int_count), 64'd3);
    q_rdy = 3'b000; cycle();
    chk("full_refill_cnt", 64'(bus.int_count), 64'd4);
    put(1'b0, 32'h0, 13'h0);
    q_rdy = 3'b111;
    repeat (5) cycle();

    // Illegal
    put(1'b1, 32'hFFFFFFFF, 13'h000);  #1;
    chk("ill_rdy", 64'(bus.in_ready), 64'd1);
    cycle();
    put(1'b0, 32'h0, 13'h0);
    chk("ill_pulse", 64'(bus.illegal), 64'd1);
    chk("ill_int_cnt", 64'(bus.int_count), 64'd0);
    cycle();
    chk("ill_pulse_end", 64'(bus.illegal), 64'd0);
    q_rdy = 3'b000;
    put(1'b1, 32'h002081B3, C_RT);  cycle();
    chk("ill_next_tag", 64'(bus.int_tag), 64'd9);
    put(1'b0, 32'h0, 13'h0);
    q_rdy = 3'b111; cycle();

    // Tag wrap from a fresh reset, popping continuously
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      put(1'b1, 32'h1000 + 32'(i), (i % 3 == 0) ? C_RT : (i % 3 == 1) ? C_LW : C_BEQ);
      cycle();
    end
    chk("wrap_tag", 64'(bus.mem_tag), 64'd0);
    chk("wrap_valid", 64'(bus.mem_valid), 64'd1);
    put(1'b0, 32'h0, 13'h0);
    cycle(); cycle();

    // Simultaneous push/pop on mem
    q_rdy = 3'b000;
    put(1'b1, 32'h0000A103, C_LW);  cycle();
    put(1'b1, 32'h0040A183, C_LW);  cycle();
    put(1'b1, 32'h0020A023, C_SW);
    q_rdy = 3'b010; cycle();
    chk("pp_cnt", 64'(bus.mem_count), 64'd2);
    chk("pp_head_tag", 64'(bus.mem_tag), 64'd2);
    put(1'b0, 32'h0, 13'h0);
    cycle();
    chk("pp_sw_tag", 64'(bus.mem_tag), 64'd3);
    cycle(); cycle();

    // Flush with tag = 9 and all FIFOs occupied
    q_rdy = 3'b000;
    put(1'b1, 32'h002081B3, C_RT);   cycle();
    put(1'b1, 32'h0000A103, C_LW);   cycle();
    put(1'b1, 32'h00208463, C_BEQ);  cycle();
    put(1'b1, 32'h002081B3, C_RT);   cycle();
    put(1'b1, 32'h0000A103, C_LW);   cycle();
    put(1'b1, 32'h00308133, C_RT);
    bus.flush = 1'b1;  #1;
    chk("flush_rdy", 64'(bus.in_ready), 64'd0);
    cycle();
    bus.flush = 1'b0;
    chk("flush_cnt", 64'({bus.int_count, bus.mem_count, bus.br_count}), 64'd0);
    put(1'b1, 32'h00308133, C_RT);  cycle();
    chk("flush_tag", 64'(bus.int_tag), 64'd9);
    chk("flush_int_cnt", 64'(bus.int_count), 64'd1);

    // Reset mid-stream
    put(1'b1, 32'h00208463, C_BEQ);  cycle();
    rst = 1'b1;
    put(1'b1, 32'h0000A103, C_LW);  #1;
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    cycle(); cycle();
    rst = 1'b0;
    put(1'b1, 32'h00208463, C_BEQ);  cycle();
    chk("rst_tag", 64'(bus.br_tag), 64'd0);
    chk("rst_br_cnt", 64'(bus.br_count), 64'd1);
    put(1'b0, 32'h0, 13'h0);
    q_rdy = 3'b111;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
